// File: rtl/loader_pkg.sv
// loader_pkg
//   Shared definitions for the program loader: default geometry of the
//   program RAM, the pad value written during the clear phase, and the
//   loader state encoding.
//   No ports (package).
package loader_pkg;

  // Default geometry: a 4-bit PC fetches from a 16 x 8 program RAM.
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  // Value every RAM location holds after the clear phase.
  localparam logic [7:0] LOADER_PAD = 8'h00;

  // State encoding.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_LEN   = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_CHK   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERR   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_CLEAR = ST_CLEAR,
    S_LEN   = ST_LEN,
    S_DATA  = ST_DATA,
    S_CHK   = ST_CHK,
    S_DONE  = ST_DONE,
    S_ERR   = ST_ERR
  } state_t;

  // True in the states that consume bytes from the stream.
  function automatic logic stream_state(input state_t s);
    return (s == S_LEN) || (s == S_DATA) || (s == S_CHK);
  endfunction

  // True in the states where a new load may be requested.
  function automatic logic rest_state(input state_t s);
    return (s == S_IDLE) || (s == S_DONE) || (s == S_ERR);
  endfunction

endpackage

// File: rtl/program_ram.sv
// program_ram
//   2**ADDR_W x DATA_W program memory. One synchronous write port used by
//   the loader, one asynchronous read port used by the CPU fetch path.
//   Contents are not reset. A read of the address being written returns
//   the old contents until the write edge.
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address (CPU PC)
//   rdata  out  mem[raddr], combinational
module program_ram
  import loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/program_loader.sv
// program_loader
//   Writer side of the instruction fetch path. Receives a framed byte
//   stream (length, N instruction bytes, XOR checksum) over valid/ready,
//   clears and then fills the program RAM, and keeps the CPU in reset
//   until a load finishes with a matching checksum.
// Ports:
//   clk           in   system clock
//   reset         in   synchronous active-high reset
//   start         in   request a new load (pulse or level)
//   in_valid      in   source presents a byte on in_data
//   in_data       in   stream byte
//   in_ready      out  loader accepts a byte this cycle
//   rd_addr       in   CPU fetch address
//   rd_data       out  program RAM contents at rd_addr (combinational)
//   cpu_reset     out  high while the CPU must be held in reset
//   load_done     out  last load succeeded
//   load_err      out  last load failed (bad length or checksum)
//   words_loaded  out  instruction bytes written in the current/last load
module program_loader
  import loader_pkg::*;
#(
  parameter int                ADDR_W = ADDR_W_DEF,
  parameter int                DATA_W = DATA_W_DEF,
  parameter logic [DATA_W-1:0] PAD    = DATA_W'(LOADER_PAD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  // State and datapath registers
  state_t            state_q,  state_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [ADDR_W:0]   len_q,    len_d;
  logic [ADDR_W:0]   words_q,  words_d;
  logic [DATA_W-1:0] xor_q,    xor_d;

  // Registered Moore outputs
  logic in_ready_q,  in_ready_d;
  logic cpu_reset_q, cpu_reset_d;
  logic load_done_q, load_done_d;
  logic load_err_q,  load_err_d;

  // RAM write port
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;

  // Length byte screening: zero or more bytes than the RAM holds is rejected.
  logic len_bad;

  always_comb begin
    len_bad = (in_data == '0) || (int'(in_data) > DEPTH);
  end

  // Next-state and datapath logic. Transfers are qualified with in_valid
  // only, because in the stream states in_ready_q is high by construction.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    words_d   = words_q;
    xor_d     = xor_q;
    ram_we    = 1'b0;
    ram_wdata = PAD;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_CLEAR;
          addr_d  = '0;
          words_d = '0;
          xor_d   = '0;
        end
      end

      S_CLEAR: begin
        // One location per cycle; the address wraps back to 0 on the last
        // write so the data phase starts at the bottom of the RAM.
        ram_we    = 1'b1;
        ram_wdata = PAD;
        addr_d    = addr_q + 1'b1;
        if (addr_q == ADDR_LAST) begin
          state_d = S_LEN;
        end
      end

      S_LEN: begin
        if (in_valid) begin
          if (len_bad) begin
            state_d = S_ERR;
          end else begin
            len_d   = in_data[ADDR_W:0];
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (in_valid) begin
          ram_we    = 1'b1;
          ram_wdata = in_data;
          xor_d     = xor_q ^ in_data;
          addr_d    = addr_q + 1'b1;
          words_d   = words_q + 1'b1;
          // words_q counts bytes already stored, so this is the L-th byte.
          if ((words_q + 1'b1) == len_q) begin
            state_d = S_CHK;
          end
        end
      end

      S_CHK: begin
        if (in_valid) begin
          state_d = (in_data == xor_q) ? S_DONE : S_ERR;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so after each
  // edge they reflect exactly the state register.
  always_comb begin
    in_ready_d  = stream_state(state_d);
    cpu_reset_d = (state_d != S_DONE);
    load_done_d = (state_d == S_DONE);
    load_err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      words_q     <= '0;
      xor_q       <= '0;
      in_ready_q  <= 1'b0;
      cpu_reset_q <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      words_q     <= words_d;
      xor_q       <= xor_d;
      in_ready_q  <= in_ready_d;
      cpu_reset_q <= cpu_reset_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  // Reset blocks the write so a reset mid-load leaves the RAM exactly as
  // it was before that edge.
  program_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we && !reset),
    .waddr (addr_q),
    .wdata (ram_wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign in_ready     = in_ready_q;
  assign cpu_reset    = cpu_reset_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  assign words_loaded = words_q;

endmodule
